// File: rtl/score_display_scan_if.sv
// score_display_scan_if: BCD digits in, segment/anode pins and frame strobe out.
// master = score source side, slave = scanner side.
interface score_display_scan_if;
    logic [3:0] score0;
    logic [3:0] score1;
    logic [3:0] score2;
    logic [3:0] score3;
    logic [6:0] seg;
    logic [3:0] an;
    logic       frame;

    modport master (
        output score0, score1, score2, score3,
        input  seg, an, frame
    );

    modport slave (
        input  score0, score1, score2, score3,
        output seg, an, frame
    );
endinterface

// File: rtl/score_display_scan.sv
// score_display_scan: 4-digit common-anode scanner with per-frame snapshot.
// Optional leading-zero blanking when SCORE_LZ_BLANK_EN is defined.
module score_display_scan #(
    parameter int SCAN_DIV = 4096,
    parameter int GUARD    = 2
) (
    input logic               clk,
    input logic               reset,
    score_display_scan_if.slave bus
);
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] div_cnt;
    logic [1:0]    dig;
    logic [3:0]    snap [4];
    logic [6:0]    seg_q;
    logic [3:0]    an_q;
    logic          frame_q;
    logic [6:0]    seg_d;
    logic [3:0]    an_d;
    logic [3:0]    blank;
    logic          slot_end;
    logic          in_guard;

    assign slot_end = (div_cnt == LAST);
    assign in_guard = (int'(div_cnt) < GUARD);

    function automatic logic [6:0] enc(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

`ifdef SCORE_LZ_BLANK_EN
    // A digit is dark when it and every more significant digit are zero.
    assign blank[3] = (snap[3] == 4'd0);
    assign blank[2] = blank[3] && (snap[2] == 4'd0);
    assign blank[1] = blank[2] && (snap[1] == 4'd0);
    assign blank[0] = 1'b0;
`else
    assign blank = 4'b0000;
`endif

    // Slot timer and digit pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            dig     <= 2'd0;
        end else if (slot_end) begin
            div_cnt <= '0;
            dig     <= dig + 2'd1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Capture all four digits together at the frame boundary.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) snap[k] <= 4'd0;
        end else if (slot_end && dig == 2'd3) begin
            snap[0] <= bus.score0;
            snap[1] <= bus.score1;
            snap[2] <= bus.score2;
            snap[3] <= bus.score3;
        end
    end

    // Pick the anode and segment pattern for the current slot position.
    always_comb begin
        seg_d = 7'b1111111;
        an_d  = 4'b1111;
        if (!in_guard && !blank[dig]) begin
            an_d  = ~(4'b0001 << dig);
            seg_d = enc(snap[dig]);
        end
    end

    // Registered pin drivers; reset darkens the display immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_q   <= 7'b1111111;
            an_q    <= 4'b1111;
            frame_q <= 1'b0;
        end else begin
            seg_q   <= seg_d;
            an_q    <= an_d;
            frame_q <= slot_end && (dig == 2'd3);
        end
    end

    assign bus.seg   = seg_q;
    assign bus.an    = an_q;
    assign bus.frame = frame_q;
endmodule

// File: tb/tb_score_display_scan.sv
// tb_score_display_scan: directed checks of scan order, guard, snapshot,
// invalid BCD, leading-zero behaviour and asynchronous reset.
module tb_score_display_scan;
    localparam int SCAN_DIV = 8;
    localparam int GUARD    = 2;

`ifdef SCORE_LZ_BLANK_EN
    localparam logic [3:0] Z_AN1 = 4'b1111;
    localparam logic [3:0] Z_AN2 = 4'b1111;
    localparam logic [3:0] Z_AN3 = 4'b1111;
    localparam logic [6:0] Z_SEG = 7'b1111111;
`else
    localparam logic [3:0] Z_AN1 = 4'b1101;
    localparam logic [3:0] Z_AN2 = 4'b1011;
    localparam logic [3:0] Z_AN3 = 4'b0111;
    localparam logic [6:0] Z_SEG = 7'b1000000;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    score_display_scan_if bus ();

    score_display_scan #(
        .SCAN_DIV (SCAN_DIV),
        .GUARD    (GUARD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Walk one full slot: GUARD dark cycles, then the lit pattern.
    task automatic check_slot(input string tag, input int d,
                              input logic [3:0] ean,
                              input logic [6:0] eseg);
        for (int i = 0; i < SCAN_DIV; i++) begin
            @(posedge clk);
            #1;
            if (i < GUARD) begin
                chk({tag, "_guard_an"}, {4'd0, bus.an}, 8'h0F);
                chk({tag, "_guard_seg"}, {1'b0, bus.seg}, 8'h7F);
            end else begin
                chk({tag, "_an"}, {4'd0, bus.an}, {4'd0, ean});
                chk({tag, "_seg"}, {1'b0, bus.seg}, {1'b0, eseg});
            end
            chk({tag, "_frame"}, {7'd0, bus.frame},
                {7'd0, (d == 3 && i == SCAN_DIV - 1)});
        end
    endtask

    initial begin
        bus.score0 = 4'd4;
        bus.score1 = 4'd3;
        bus.score2 = 4'd2;
        bus.score3 = 4'd1;
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_an", {4'd0, bus.an}, 8'h0F);
        chk("rst_seg", {1'b0, bus.seg}, 8'h7F);
        chk("rst_frame", {7'd0, bus.frame}, 8'h00);
        reset = 1'b0;

        check_slot("f0d0", 0, 4'b1110, 7'b1000000);
        check_slot("f0d1", 1, Z_AN1, Z_SEG);
        check_slot("f0d2", 2, Z_AN2, Z_SEG);
        check_slot("f0d3", 3, Z_AN3, Z_SEG);

        check_slot("f1d0", 0, 4'b1110, 7'b0011001);
        bus.score0 = 4'hC;
        check_slot("f1d1", 1, 4'b1101, 7'b0110000);
        check_slot("f1d2", 2, 4'b1011, 7'b0100100);
        check_slot("f1d3", 3, 4'b0111, 7'b1111001);

        check_slot("f2d0_dash", 0, 4'b1110, 7'b0111111);
        bus.score0 = 4'd9;
        bus.score1 = 4'd9;
        bus.score2 = 4'd9;
        bus.score3 = 4'd9;
        check_slot("f2d1_hold", 1, 4'b1101, 7'b0110000);
        check_slot("f2d2_hold", 2, 4'b1011, 7'b0100100);
        check_slot("f2d3_hold", 3, 4'b0111, 7'b1111001);

        check_slot("f3d0", 0, 4'b1110, 7'b0010000);
        bus.score0 = 4'd7;
        bus.score1 = 4'd0;
        bus.score2 = 4'd0;
        bus.score3 = 4'd0;
        check_slot("f3d1", 1, 4'b1101, 7'b0010000);
        check_slot("f3d2", 2, 4'b1011, 7'b0010000);
        check_slot("f3d3", 3, 4'b0111, 7'b0010000);

        check_slot("lz_d0", 0, 4'b1110, 7'b1111000);
        check_slot("lz_d1", 1, Z_AN1, Z_SEG);
        check_slot("lz_d2", 2, Z_AN2, Z_SEG);
        check_slot("lz_d3", 3, Z_AN3, Z_SEG);

        check_slot("f5d0", 0, 4'b1110, 7'b1111000);
        check_slot("f5d1", 1, Z_AN1, Z_SEG);
        repeat (4) @(posedge clk);
        #1;
        chk("mid_pre_an", {4'd0, bus.an}, {4'd0, Z_AN2});
        #2 reset = 1'b1;
        #1;
        chk("mid_async_an", {4'd0, bus.an}, 8'h0F);
        chk("mid_async_seg", {1'b0, bus.seg}, 8'h7F);
        chk("mid_async_frame", {7'd0, bus.frame}, 8'h00);
        @(posedge clk);
        #1;
        chk("mid_hold_an", {4'd0, bus.an}, 8'h0F);
        reset = 1'b0;

        check_slot("post_d0", 0, 4'b1110, 7'b1000000);
        check_slot("post_d1", 1, Z_AN1, Z_SEG);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/score_display_scan.md
# score_display_scan

Multiplexed four-digit seven-segment scanner that consumes the BCD score digits produced by the score counter and drives a common-anode display. Each frame it snapshots all four digits, then time-multiplexes them with a programmable dwell and an anti-ghosting guard. It sits between the score counter and the board's segment and anode pins.

## Interface
- SCAN_DIV, 4096: clock cycles per digit slot; must be at least GUARD+1.
- GUARD, 2: cycles at the start of each slot with all anodes off; must be at least 0.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- score0  in  4  BCD ones digit.
- score1  in  4  BCD tens digit.
- score2  in  4  BCD hundreds digit.
- score3  in  4  BCD thousands digit.
- seg  out  7  segments {g,f,e,d,c,b,a}; seg[0]=a; active-low.
- an  out  4  digit enables; an[k] drives score k; active-low, at most one low at a time.
- frame  out  1  one-cycle pulse on the first cycle a new snapshot is displayed.

## Operation
- State:
  - div_cnt: 0..SCAN_DIV-1, $clog2(SCAN_DIV) bits.
  - dig: 0..3.
  - snap[0..3]: 4 bits each.
- Every cycle, div_cnt increments.
- When div_cnt==SCAN_DIV-1:
  - div_cnt returns to 0.
  - dig advances 0→1→2→3→0.
  - If dig==3 at that edge, snap[k] loads score k for all k, and frame is 1 on the next cycle.
- Input changes mid-frame are never displayed until the next snapshot. No tearing.
- Output selection:
  - Guard: when div_cnt<GUARD, an=4'b1111 and seg=7'b1111111.
  - Otherwise: an = all ones except bit dig low; seg = enc(snap[dig]).
- enc values (seg[6:0]):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Any value 10–15 = 0111111 (dash).
- Blanked digit (see Configuration): an=4'b1111, seg=7'b1111111 for the whole slot.

## Timing
- Reset, effective immediately (asynchronous):
  - div_cnt=0, dig=0, snap=0.
  - an=4'b1111, seg=7'b1111111, frame=0.
- seg and an are registered. They reflect div_cnt, dig and snap from the previous cycle, so latency is 1 cycle.
- First post-reset frame displays snap=0000. First real snapshot loads 4·SCAN_DIV cycles after reset release.
- Frame period is 4·SCAN_DIV cycles. Each slot is lit for SCAN_DIV−GUARD cycles.
- Reset asserted mid-slot: outputs go dark the same instant. Scanning restarts at digit 0 with div_cnt=0.
- GUARD=0: there are no dark cycles; anodes switch directly between digits.

## Configuration
- Macro SCORE_LZ_BLANK_EN.
- Defined: leading-zero blanking.
  - Digit k (k=3,2,1) is blanked when snap[k]..snap[3] are all 0.
  - Digit 0 is never blanked.
  - Invalid digits (10–15) count as nonzero.
- Undefined: all four digits are always shown.

## Test plan
All scenarios use SCAN_DIV=8, GUARD=2.
- Reset:
  - Stimulus: hold reset, then release.
  - Required: an=1111, seg=1111111, frame=0 while reset is held.
  - Required: the first frame shows 0 on every unblanked digit.
- Normal scan:
  - Stimulus: scores 3,2,1,0 = 1,2,3,4.
  - Required: frame pulses at cycle 32 after reset release.
  - Required: the digit-0 slot shows 2 dark cycles, then an=1110, seg=0011001 for 6 cycles.
  - Required: then digit 1 shows an=1101, seg=0110000; digit 2 shows seg=0100100; digit 3 shows seg=1111001.
- Invalid BCD:
  - Stimulus: score0=4'hC.
  - Required: the digit-0 slot shows seg=0111111.
- Snapshot stability:
  - Stimulus: change scores to 9,9,9,9 during the digit-1 slot.
  - Required: the old values display until the next frame pulse, then 0010000 on every digit.
- Leading-zero blanking:
  - Stimulus: scores 0,0,0,7.
  - Required with SCORE_LZ_BLANK_EN: slots 1–3 stay an=1111, and slot 0 shows 1111000.
  - Required without the macro: slots 1–3 show 1000000.
- Mid-scan reset:
  - Stimulus: assert reset during the digit-2 slot.
  - Required: an=1111 asynchronously.
  - Required: after release, the digit-0 guard begins on the next edge.
